// File: rtl/gf_matvec_stream_pkg.sv
// gf_pkg: shared types and constants for the GF(2^N) matrix-vector stream block.
//   state_t   - sequencer states
//   AES_POLY  - x^8 + x^4 + x^3 + x + 1, the AES / MixColumns field polynomial
//   cnt_w()   - width of a counter that indexes n items (at least 1 bit)
package gf_pkg;

  typedef enum logic [1:0] {LOAD_A, LOAD_B, COMPUTE, DRAIN} state_t;

  localparam logic [8:0] AES_POLY = 9'h11B;

  function automatic int cnt_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/gf_matvec_stream_mult.sv
// matrix_multiplication: combinational GF(2^N) matrix product s = a * b.
//   p : irreducible polynomial including the x^N term
//   a : ROW_A x COL_A operand, row-major, element 0 in the low word
//   b : COL_A x COL_B operand, row-major
//   s : ROW_A x COL_B product, row-major
module matrix_multiplication #(
  parameter int N     = 8,
  parameter int COL_A = 4,
  parameter int ROW_A = 4,
  parameter int COL_B = 1
) (
  input  logic [N:0]                        p,
  input  logic [ROW_A*COL_A-1:0][N-1:0]     a,
  input  logic [COL_A*COL_B-1:0][N-1:0]     b,
  output logic [ROW_A*COL_B-1:0][N-1:0]     s
);

  // Full carry-less product first, then fold the high bits back down with
  // shifted copies of p; bit N of p cancels the bit being folded.
  function automatic logic [N-1:0] gf_mul(input logic [N-1:0] x,
                                          input logic [N-1:0] y,
                                          input logic [N:0]   pp);
    logic [2*N-2:0] prod;
    prod = '0;
    for (int i = 0; i < N; i++)
      if (y[i]) prod = prod ^ ((2*N-1)'(x) << i);
    for (int i = 2*N-2; i >= N; i--)
      if (prod[i]) prod = prod ^ ((2*N-1)'(pp) << (i-N));
    return prod[N-1:0];
  endfunction

  always_comb begin
    s = '0;
    for (int r = 0; r < ROW_A; r++)
      for (int c = 0; c < COL_B; c++)
        for (int k = 0; k < COL_A; k++)
          s[r*COL_B+c] = s[r*COL_B+c] ^ gf_mul(a[r*COL_A+k], b[k*COL_B+c], p);
  end

endmodule

// File: rtl/gf_matvec_stream.sv
// gf_matvec_stream: streams in A then B (row-major, valid/ready), runs one
// combinational GF(2^N) matrix multiply, streams the product out.
//   clk, rst             - clock, synchronous active-high reset
//   p                    - field polynomial, latched on the first A word
//   in_data/in_valid/in_ready    - operand word stream
//   out_data/out_valid/out_ready - result word stream (out_data registered)
//   busy                 - low only when idle in LOAD_A with nothing loaded
module gf_matvec_stream
  import gf_pkg::*;
#(
  parameter int N     = 8,
  parameter int ROW_A = 4,
  parameter int COL_A = 4,
  parameter int COL_B = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N:0]   p,
  input  logic [N-1:0] in_data,
  input  logic         in_valid,
  output logic         in_ready,
  output logic [N-1:0] out_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic         busy
);

  localparam int NA = ROW_A*COL_A;
  localparam int NB = COL_A*COL_B;
  localparam int NR = ROW_A*COL_B;
  localparam int AW = cnt_w(NA);
  localparam int BW = cnt_w(NB);
  localparam int RW = cnt_w(NR);

  state_t                 state;
  logic [AW-1:0]          a_cnt;
  logic [BW-1:0]          b_cnt;
  logic [RW-1:0]          o_cnt;
  logic [RW-1:0]          o_nxt;
  logic [NA-1:0][N-1:0]   a_buf;
  logic [NB-1:0][N-1:0]   b_buf;
  logic [NR-1:0][N-1:0]   res_buf;
  logic [NR-1:0][N-1:0]   s;
  logic [N:0]             p_lat;

  matrix_multiplication #(.N(N), .COL_A(COL_A), .ROW_A(ROW_A), .COL_B(COL_B)) u_mul (
    .p (p_lat),
    .a (a_buf),
    .b (b_buf),
    .s (s)
  );

  // Handshake flags decode from state only, so in_ready never looks at in_valid.
  assign in_ready  = (state == LOAD_A) || (state == LOAD_B);
  assign out_valid = (state == DRAIN);
  assign busy      = !((state == LOAD_A) && (a_cnt == '0));
  assign o_nxt     = o_cnt + 1'b1;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= LOAD_A;
      a_cnt    <= '0;
      b_cnt    <= '0;
      o_cnt    <= '0;
      a_buf    <= '0;
      b_buf    <= '0;
      res_buf  <= '0;
      p_lat    <= '0;
      out_data <= '0;
    end else begin
      case (state)
        LOAD_A: if (in_valid) begin
          a_buf[a_cnt] <= in_data;
          if (a_cnt == '0) p_lat <= p;
          if (a_cnt == AW'(NA-1)) begin
            a_cnt <= '0;
            state <= LOAD_B;
          end else a_cnt <= a_cnt + 1'b1;
        end
        LOAD_B: if (in_valid) begin
          b_buf[b_cnt] <= in_data;
          if (b_cnt == BW'(NB-1)) begin
            b_cnt <= '0;
            state <= COMPUTE;
          end else b_cnt <= b_cnt + 1'b1;
        end
        COMPUTE: begin
          res_buf  <= s;
          out_data <= s[0];
          o_cnt    <= '0;
          state    <= DRAIN;
        end
        DRAIN: if (out_ready) begin
          // out_data advances on the same edge as the beat that consumed it.
          if (o_cnt == RW'(NR-1)) begin
            o_cnt <= '0;
            state <= LOAD_A;
          end else begin
            o_cnt    <= o_nxt;
            out_data <= res_buf[o_nxt];
          end
        end
        default: state <= LOAD_A;
      endcase
    end
  end

endmodule

// File: tb/tb_gf_matvec_stream.sv
// tb_gf_matvec_stream: directed vectors for gf_matvec_stream (N=8, 4x4 * 4x1)
// with hand-computed GF(2^8) results, including gaps, backpressure, resets
// and polynomial latching.
module tb_gf_matvec_stream;

  logic       clk = 1'b0;
  logic       rst;
  logic [8:0] p;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready;
  logic       busy;

  int total = 0;
  int bad   = 0;

  logic [7:0] ma [16];
  logic [7:0] vb [4];
  logic [7:0] ex [4];

  always #5 clk = ~clk;

  gf_matvec_stream #(.N(8), .ROW_A(4), .COL_A(4), .COL_B(1)) dut (
    .clk       (clk),
    .rst       (rst),
    .p         (p),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .busy      (busy)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Present one word and hold it until the edge that accepts it.
  task automatic push(input logic [7:0] d, input bit gaps);
    int n;
    if (gaps) begin
      in_valid = 1'b0;
      repeat ($urandom_range(0, 2)) tick();
    end
    in_valid = 1'b1;
    in_data  = d;
    n = 0;
    while (!in_ready && n < 50) begin
      tick();
      n++;
    end
    if (n >= 50) chk("in_ready_timeout", 0, 1);
    tick();
  endtask

  // Load ma/vb, check latency, drain n_out results against ex.
  // p0 is driven for word 0, p1 from then on.
  task automatic run(input string tag, input logic [8:0] p0, input logic [8:0] p1,
                     input bit gaps, input bit bp, input int n_out);
    p = p0;
    for (int i = 0; i < 16; i++) begin
      push(ma[i], gaps);
      if (i == 0) p = p1;
    end
    for (int i = 0; i < 4; i++) push(vb[i], gaps);
    chk({tag, "_compute_ovalid"}, out_valid, 0);
    chk({tag, "_compute_iready"}, in_ready, 0);
    tick();
    chk({tag, "_first_ovalid"}, out_valid, 1);
    for (int i = 0; i < n_out; i++) begin
      if (bp) begin
        repeat ($urandom_range(1, 3)) begin
          chk({tag, "_hold_valid"}, out_valid, 1);
          chk({tag, "_hold_data"}, out_data, ex[i]);
          tick();
        end
      end
      chk($sformatf("%s_out%0d", tag, i), out_data, ex[i]);
      chk({tag, "_drain_valid"}, out_valid, 1);
      chk({tag, "_drain_iready"}, in_ready, 0);
      chk({tag, "_drain_busy"}, busy, 1);
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
    end
    if (n_out == 4) begin
      chk({tag, "_end_ovalid"}, out_valid, 0);
      chk({tag, "_end_iready"}, in_ready, 1);
      chk({tag, "_end_busy"}, busy, 0);
    end
    in_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b1; p = 9'h0; in_data = 8'h0; in_valid = 1'b0; out_ready = 1'b0;
    tick();
    tick();
    chk("rst_iready", in_ready, 1);
    chk("rst_ovalid", out_valid, 0);
    chk("rst_odata", out_data, 0);
    chk("rst_busy", busy, 0);
    rst = 1'b0;

    // MixColumns, continuous valid
    ma = '{8'h02, 8'h03, 8'h01, 8'h01, 8'h01, 8'h02, 8'h03, 8'h01,
           8'h01, 8'h01, 8'h02, 8'h03, 8'h03, 8'h01, 8'h01, 8'h02};
    vb = '{8'hdb, 8'h13, 8'h53, 8'h45};
    ex = '{8'h8e, 8'h4d, 8'ha1, 8'hbc};
    run("mix1", 9'h11B, 9'h11B, 1'b0, 1'b0, 4);

    // Back-to-back, same A
    vb = '{8'hf2, 8'h0a, 8'h22, 8'h5c};
    ex = '{8'h9f, 8'hdc, 8'h58, 8'h9d};
    run("mix2", 9'h11B, 9'h11B, 1'b0, 1'b0, 4);

    // Identity
    ma = '{8'h01, 8'h00, 8'h00, 8'h00, 8'h00, 8'h01, 8'h00, 8'h00,
           8'h00, 8'h00, 8'h01, 8'h00, 8'h00, 8'h00, 8'h00, 8'h01};
    vb = '{8'h01, 8'h80, 8'hff, 8'h00};
    ex = '{8'h01, 8'h80, 8'hff, 8'h00};
    run("ident", 9'h11B, 9'h11B, 1'b0, 1'b0, 4);

    // Zero matrix
    for (int i = 0; i < 16; i++) ma[i] = 8'h00;
    vb = '{8'hdb, 8'h13, 8'h53, 8'h45};
    ex = '{8'h00, 8'h00, 8'h00, 8'h00};
    run("zero", 9'h11B, 9'h11B, 1'b0, 1'b0, 4);

    // Gaps and backpressure on MixColumns
    ma = '{8'h02, 8'h03, 8'h01, 8'h01, 8'h01, 8'h02, 8'h03, 8'h01,
           8'h01, 8'h01, 8'h02, 8'h03, 8'h03, 8'h01, 8'h01, 8'h02};
    ex = '{8'h8e, 8'h4d, 8'ha1, 8'hbc};
    run("gaps", 9'h11B, 9'h11B, 1'b1, 1'b1, 4);

    // Reset after 7 A words; in_valid stays high on the reset edge
    p = 9'h11B;
    for (int i = 0; i < 7; i++) push(ma[i], 1'b0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    in_valid = 1'b0;
    chk("rstload_iready", in_ready, 1);
    chk("rstload_busy", busy, 0);
    chk("rstload_ovalid", out_valid, 0);
    run("reload", 9'h11B, 9'h11B, 1'b0, 1'b0, 4);

    // Reset during DRAIN after 2 outputs
    run("drainrst", 9'h11B, 9'h11B, 1'b0, 1'b0, 2);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rstdrain_ovalid", out_valid, 0);
    chk("rstdrain_busy", busy, 0);
    chk("rstdrain_odata", out_data, 0);
    chk("rstdrain_iready", in_ready, 1);
    vb = '{8'hf2, 8'h0a, 8'h22, 8'h5c};
    ex = '{8'h9f, 8'hdc, 8'h58, 8'h9d};
    run("afterrst", 9'h11B, 9'h11B, 1'b0, 1'b0, 4);

    // p changes after word 0: 0x11B still applies (02*80=1b, 03*80=9b)
    vb = '{8'h80, 8'h00, 8'h00, 8'h00};
    ex = '{8'h1b, 8'h80, 8'h80, 8'h9b};
    run("plat", 9'h11B, 9'h11D, 1'b0, 1'b0, 4);
    // Next run under 0x11D (02*80=1d, 03*80=9d)
    ex = '{8'h1d, 8'h80, 8'h80, 8'h9d};
    run("p11d", 9'h11D, 9'h11D, 1'b0, 1'b0, 4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
